// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: pixel width, window size,
// counter width and window-generator state encoding.
package cnn_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 3;
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } win_state_t;

endpackage

// File: rtl/window_shift_row.sv
// One window row: WIN_N-tap shift register, element 0 oldest,
// new sample enters the top (newest) element when en is high.
module window_shift_row
  import cnn_pkg::*;
#(
  parameter int WIDTH = PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [WIDTH-1:0]       d,
  output logic [WIN_N*WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {d, q[WIN_N*WIDTH-1:WIDTH]};
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding window generator fed by two external line buffers.
// Define WIN_STRIDE2_EN to emit only every second window in each axis.
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int WIDTH      = PIX_W,
  parameter int IMG_WIDTH  = 482,
  parameter int IMG_HEIGHT = 482
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             pix_in,
  input  logic [WIDTH-1:0]             tap1_in,
  input  logic [WIDTH-1:0]             tap2_in,
  input  logic                         valid_in,
  output logic [WIN_N*WIN_N*WIDTH-1:0] win_out,
  output logic                         win_valid,
  output logic                         frame_done
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] EDGE     = CNT_W'(WIN_N - 1);

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  win_state_t       state;

  logic [WIN_N*WIDTH-1:0] q0;
  logic [WIN_N*WIDTH-1:0] q1;
  logic [WIN_N*WIDTH-1:0] q2;

  logic col_end;
  logic frame_end;
  logic in_win;
  logic emit;

  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end && (row == ROW_LAST);
  assign in_win    = (row >= EDGE) && (col >= EDGE);

`ifdef WIN_STRIDE2_EN
  // (row-2) and (col-2) even is the same as row and col even
  assign emit = in_win && !row[0] && !col[0];
`else
  assign emit = in_win;
`endif

  window_shift_row #(.WIDTH(WIDTH)) u_row0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid_in),
    .d     (tap2_in),
    .q     (q0)
  );

  window_shift_row #(.WIDTH(WIDTH)) u_row1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid_in),
    .d     (tap1_in),
    .q     (q1)
  );

  window_shift_row #(.WIDTH(WIDTH)) u_row2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (valid_in),
    .d     (pix_in),
    .q     (q2)
  );

  assign win_out = {q2, q1, q0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      state      <= IDLE;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= valid_in && emit;
      frame_done <= valid_in && frame_end;
      if (valid_in) begin
        if (col_end) begin
          col <= '0;
          row <= frame_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        case (state)
          IDLE: state <= frame_end ? IDLE : PRIME;
          PRIME: begin
            if (frame_end)
              state <= IDLE;
            else if (row == EDGE && col == '0)
              state <= RUN;
          end
          RUN: if (frame_end) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 5x4 frame,
// pixel value = row*16+col.
module tb_window_gen_3x3;

  localparam int W  = 8;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int WB = 9 * W;

`ifdef WIN_STRIDE2_EN
  localparam int WIN_PER_FRAME = 2;
`else
  localparam int WIN_PER_FRAME = 6;
`endif

  typedef struct {
    logic [WB-1:0] win;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  pix_in = '0;
  logic [W-1:0]  tap1_in = '0;
  logic [W-1:0]  tap2_in = '0;
  logic          valid_in = 1'b0;
  logic [WB-1:0] win_out;
  logic          win_valid;
  logic          frame_done;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;

  window_gen_3x3 #(
    .WIDTH      (W),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .tap1_in    (tap1_in),
    .tap2_in    (tap2_in),
    .valid_in   (valid_in),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [WB-1:0] act,
                       logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pv(int r, int c);
    return W'(r * 16 + c);
  endfunction

  function automatic logic [WB-1:0] exp_win(int r, int c);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*W +: W] = pv(r - 2 + k / 3, c - 2 + k % 3);
    return w;
  endfunction

  function automatic bit emits(int r, int c);
`ifdef WIN_STRIDE2_EN
    return r >= 2 && c >= 2 && (r % 2 == 0) && (c % 2 == 0);
`else
    return r >= 2 && c >= 2;
`endif
  endfunction

  task automatic send(int r, int c);
    exp_t e;
    @(negedge clk);
    pix_in   = pv(r, c);
    tap1_in  = (r >= 1) ? pv(r - 1, c) : W'(8'hE0 + c);
    tap2_in  = (r >= 2) ? pv(r - 2, c) : W'(8'hD0 + c);
    valid_in = 1'b1;
    if (emits(r, c)) begin
      e.win  = exp_win(r, c);
      e.last = (r == IH - 1) && (c == IW - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      pix_in   = 8'h5A;
    end
  endtask

  task automatic frame(int gap);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        send(r, c);
        if (gap > 0) idle(gap);
      end
  endtask

  task automatic drain_and_count(string name, int nwin, int ndone);
    int t;
    t = 0;
    idle(2);
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, WB'(sb_q.size()), '0);
    check({name, "_wins"}, WB'(win_cnt), WB'(nwin));
    check({name, "_dones"}, WB'(done_cnt), WB'(ndone));
    sb_q.delete();
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic check_zero(string name);
    check({name, "_win_out"}, win_out, '0);
    check({name, "_win_valid"}, WB'(win_valid), '0);
    check({name, "_frame_done"}, WB'(frame_done), '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (win_valid) begin
      win_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_win: got %h expected none", win_out);
      end else begin
        e = sb_q.pop_front();
        check("win_out", win_out, e.win);
        check("done_with_win", WB'(frame_done), WB'(e.last));
      end
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_in = 1'b1;
    pix_in   = 8'hFF;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n    = 1'b1;
    valid_in = 1'b0;
    idle(1);

    frame(0);
    drain_and_count("cont", WIN_PER_FRAME, 1);

    frame(3);
    drain_and_count("gaps", WIN_PER_FRAME, 1);

    frame(0);
    frame(0);
    drain_and_count("b2b", 2 * WIN_PER_FRAME, 2);

    for (int c = 0; c < IW; c++) send(0, c);
    for (int c = 0; c < IW; c++) send(1, c);
    send(2, 0);
    send(2, 1);
    send(2, 2);
    @(negedge clk);
    rst_n    = 1'b0;
    pix_in   = pv(2, 3);
    tap1_in  = pv(1, 3);
    tap2_in  = pv(0, 3);
    valid_in = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst_n    = 1'b1;
    valid_in = 1'b0;
    sb_q.delete();
    win_cnt  = 0;
    done_cnt = 0;
    frame(0);
    drain_and_count("post_rst", WIN_PER_FRAME, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel bit width.
REQ-002 SHALL have parameter IMG_WIDTH, default 482, pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 482, rows per frame.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pix_in  input  WIDTH  current-row pixel.
REQ-007 SHALL have port tap1_in  input  WIDTH  same column, one row earlier (first line-buffer output).
REQ-008 SHALL have port tap2_in  input  WIDTH  same column, two rows earlier (second line-buffer output).
REQ-009 SHALL have port valid_in  input  1  qualifies pix_in/tap1_in/tap2_in in the same cycle.
REQ-010 SHALL have port win_out  output  9*WIDTH  3x3 window; element k=3*r+c at bits [k*WIDTH +: WIDTH]; r=0 is tap2 row, c=0 is oldest column.
REQ-011 SHALL have port win_valid  output  1  win_out holds a complete in-image window.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-013 SHALL keep col counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1, 9 bits each, advancing only on valid_in.
REQ-014 SHALL wrap col to 0 and increment row at col==IMG_WIDTH-1; at the last pixel of the frame SHALL wrap both to 0.
REQ-015 SHALL shift each of the three row registers one column on valid_in (pix_in into r=2, tap1_in into r=1, tap2_in into r=0, column c=2 newest).
REQ-016 SHALL ignore tap contents for rows 0..1; they enter shift registers but never appear under win_valid.
REQ-017 SHALL assert win_valid one cycle after an accepted pixel with row>=2 and col>=2 (latency 1); deassert otherwise.
REQ-018 SHALL hold win_out, counters and state when valid_in is low; gaps of any length SHALL NOT alter window content.
REQ-019 SHALL run a state machine IDLE -> PRIME (first accepted pixel) -> RUN (first pixel of row 2) -> IDLE (last pixel of frame).
REQ-020 SHALL pulse frame_done one cycle after the last pixel, coincident with that pixel's win_valid.
REQ-021 SHALL accept a back-to-back next frame: pixel (0,0) in the cycle following the last pixel SHALL be counted as a new frame with no lost cycle.
REQ-022 SHALL not emit windows spanning row or frame boundaries (col<2 suppression at every row start).

Reset
REQ-023 SHALL on rst_n low at a clock edge clear col, row, shift registers, win_out to 0, win_valid and frame_done to 0, state to IDLE.
REQ-024 SHALL treat a reset mid-frame as abandoning the frame; the next accepted pixel is (0,0).

Configuration
REQ-025 SHALL, with macro WIN_STRIDE2_EN defined, assert win_valid only when (row-2) and (col-2) are both even; shifting and counting unchanged.
REQ-026 SHALL, without WIN_STRIDE2_EN, emit a window at every position per REQ-017 (stride 1).

Structure
REQ-027 SHALL take WIDTH default, window size 3 and the state encoding (IDLE, PRIME, RUN) from shared package cnn_pkg.
REQ-028 SHALL instantiate sub-module window_shift_row (3-tap WIDTH-bit shift register with enable) three times.

Verification (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col, taps driven consistently)
REQ-029 Continuous frame, stride 1 -> exactly 6 win_valid pulses; first win_out elements 0..8 = 00,01,02,10,11,12,20,21,22 hex; frame_done with the 6th.
REQ-030 Same frame with WIN_STRIDE2_EN -> exactly 2 windows, centred at (1,1) and (1,3); frame_done still pulses once.
REQ-031 valid_in low for 3 cycles between every pixel -> identical window sequence and values to REQ-029, win_valid never asserted during gaps.
REQ-032 Two frames back-to-back with no idle cycle -> 12 windows, 2 frame_done pulses; first window of frame 2 contains no frame-1 row-3 data under win_valid.
REQ-033 rst_n low at pixel (2,3) for one cycle, then full frame -> all outputs 0 during reset, then 6 correct windows.
